regfile_wb_arbiter: RTL

//  Shares the register file's single write port between the ALU and load-unit write-back streams.

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Purpose : Round-robin ALU/load write-back arbiter with pending-write scoreboard.
//           Optional forwarding ports under macro WB_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter logic [4:0] WB_UOP   = 5'd1,
  parameter logic [4:0] IDLE_UOP = 5'd0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_iss_valid,
  input  logic [3:0]  i_iss_sel,
  output logic        o_iss_ready,
  input  logic [3:0]  i_chk_sel_a,
  input  logic [3:0]  i_chk_sel_b,
  output logic        o_chk_hazard,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [3:0]  i_alu_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_alu_flags_we,
  input  logic [3:0]  i_alu_flags,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [3:0]  i_mem_sel,
  input  logic [31:0] i_mem_data,
  input  logic [3:0]  i_rf_cur_flags,
  output logic        o_rf_not_enable,
  output logic [4:0]  o_rf_uop,
  output logic [3:0]  o_rf_sel_in,
  output logic [31:0] o_rf_in_reg,
  output logic [3:0]  o_rf_in_flags,
  output logic [14:0] o_pending,
  output logic        o_err_bad_sel
`ifdef WB_BYPASS_EN
  ,
  output logic        o_byp_valid,
  output logic [3:0]  o_byp_sel,
  output logic [31:0] o_byp_data
`endif
);

  logic        r_last_mem;   // 1: MEM won the last contention, ALU is next
  logic [14:0] r_pending;

  logic [15:0] w_pend16;
  logic        w_grant_alu;
  logic        w_grant_mem;
  logic        w_acc_alu;
  logic        w_acc_mem;
  logic        w_contended;
  logic        w_wb_any;
  logic        w_wb_write;
  logic [3:0]  w_wb_sel;
  logic [31:0] w_wb_data;
  logic [3:0]  w_wb_flags;
  logic [14:0] w_clr;
  logic [14:0] w_set;
  logic        w_haz_a;
  logic        w_haz_b;

  assign w_pend16    = {1'b0, r_pending};
  assign w_contended = i_alu_valid && i_mem_valid;
  assign w_grant_alu = i_alu_valid && (!i_mem_valid || r_last_mem);
  assign w_grant_mem = i_mem_valid && (!i_alu_valid || !r_last_mem);
  assign o_alu_ready = !i_stall && w_grant_alu;
  assign o_mem_ready = !i_stall && w_grant_mem;
  assign w_acc_alu   = i_alu_valid && o_alu_ready;
  assign w_acc_mem   = i_mem_valid && o_mem_ready;

  assign w_wb_any   = w_acc_alu || w_acc_mem;
  assign w_wb_sel   = w_acc_alu ? i_alu_sel  : i_mem_sel;
  assign w_wb_data  = w_acc_alu ? i_alu_data : i_mem_data;
  assign w_wb_flags = (w_acc_alu && i_alu_flags_we) ? i_alu_flags : i_rf_cur_flags;
  assign w_wb_write = w_wb_any && (w_wb_sel != 4'd15);

  assign o_iss_ready = !i_stall && !w_pend16[i_iss_sel];
  assign w_clr = w_wb_write ? (15'd1 << w_wb_sel) : 15'd0;
  assign w_set = (i_iss_valid && o_iss_ready && (i_iss_sel != 4'd15)) ? (15'd1 << i_iss_sel) : 15'd0;

`ifdef WB_BYPASS_EN
  logic [15:0] w_clr16;

  assign o_byp_valid = !o_rf_not_enable;
  assign o_byp_sel   = o_rf_sel_in;
  assign o_byp_data  = o_rf_in_reg;
  assign w_clr16     = {1'b0, w_clr};
  // A clearing source already sitting in the forwarding stage is not a hazard.
  assign w_haz_a = w_pend16[i_chk_sel_a] &&
                   !(w_clr16[i_chk_sel_a] && o_byp_valid && (o_byp_sel == i_chk_sel_a));
  assign w_haz_b = w_pend16[i_chk_sel_b] &&
                   !(w_clr16[i_chk_sel_b] && o_byp_valid && (o_byp_sel == i_chk_sel_b));
`else
  assign w_haz_a = w_pend16[i_chk_sel_a];
  assign w_haz_b = w_pend16[i_chk_sel_b];
`endif

  assign o_chk_hazard = w_haz_a || w_haz_b;
  assign o_pending    = r_pending;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_mem      <= 1'b1;
      r_pending       <= 15'd0;
      o_rf_not_enable <= 1'b1;
      o_rf_uop        <= IDLE_UOP;
      o_rf_sel_in     <= 4'd0;
      o_rf_in_reg     <= 32'd0;
      o_rf_in_flags   <= 4'd0;
      o_err_bad_sel   <= 1'b0;
    end else begin
      if (w_contended && w_wb_any)
        r_last_mem <= w_acc_mem;
      // Set is applied after clear so a same-edge reissue keeps the bit.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wb_write) begin
        o_rf_not_enable <= 1'b0;
        o_rf_uop        <= WB_UOP;
        o_rf_sel_in     <= w_wb_sel;
        o_rf_in_reg     <= w_wb_data;
        o_rf_in_flags   <= w_wb_flags;
      end else begin
        o_rf_not_enable <= 1'b1;
        o_rf_uop        <= IDLE_UOP;
      end
      if (w_wb_any && (w_wb_sel == 4'd15))
        o_err_bad_sel <= 1'b1;
    end
  end

endmodule
`default_nettype wire
